// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP definitions for the parser and the tx frame builder.
package eth_pkg;

  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned IP_HDR_LEN    = 20;
  localparam int unsigned UDP_HDR_LEN   = 8;
  localparam int unsigned HDR_LEN       = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int unsigned MIN_FRAME_LEN = 60;
  localparam int unsigned CSUM_LATENCY  = 3;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IPV4_VER_IHL   = 16'h4500;
  localparam logic [15:0] IPV4_FLAGS_DF  = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_PAY,
    ST_PAD,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/ipv4_csum.sv
// IPv4 header checksum: 10-word one's-complement sum, two carry folds, invert.
// Fixed 3-cycle latency from inputs to csum.
module ipv4_csum
  import eth_pkg::*;
#(
  parameter logic [31:0] SRC_IP = 32'hC0A8_010A,
  parameter logic [31:0] DST_IP = 32'hE936_0C6F,
  parameter logic [7:0]  IP_TTL = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] total_len,
  input  logic [15:0] ident,
  output logic [15:0] csum
);

  logic [19:0] sum_c;
  logic [19:0] sum_q;
  logic [16:0] fold_q;

  // Sum of all ten header words with the checksum field taken as zero.
  always_comb begin
    sum_c = 20'(IPV4_VER_IHL) + 20'(total_len) + 20'(ident) + 20'(IPV4_FLAGS_DF)
          + 20'({IP_TTL, IP_PROTO_UDP})
          + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
          + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  end

  // Stage 1 registers the raw sum, stage 2 folds once, stage 3 folds again and inverts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      fold_q <= '0;
      csum   <= '0;
    end else begin
      sum_q  <= sum_c;
      fold_q <= 17'(sum_q[15:0]) + 17'(sum_q[19:16]);
      csum   <= ~(fold_q[15:0] + 16'(fold_q[16]));
    end
  end

endmodule

// File: rtl/eth_udp_tx_builder.sv
// Builds Ethernet/IPv4/UDP frames (no preamble/SFD/FCS), one byte per cycle,
// ahead of the RGMII transmitter. All tx outputs are registered.
module eth_udp_tx_builder
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'h01_00_5E_36_0C_6F,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
  parameter logic [31:0] DST_IP      = 32'hE936_0C6F,
  parameter logic [15:0] SRC_PORT    = 16'd26400,
  parameter logic [15:0] DST_PORT    = 16'd26477,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        startIn,
  input  logic [10:0] payloadLenIn,
  output logic        busyOut,
  input  logic [7:0]  payloadDataIn,
  input  logic        payloadValidIn,
  output logic        payloadReadyOut,
  output logic [7:0]  txDataOut,
  output logic        txDataValidOut,
  output logic        txErrOut,
  output logic        frameDoneOut,
  output logic        startErrOut
);

  tx_state_t   state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [10:0] len_q, len_n;
  logic [15:0] frame_id, frame_id_n;
  logic [15:0] id_cnt, id_cnt_n;
  logic [7:0]  tx_data_n;
  logic        tx_valid_n, tx_err_n, done_n, start_err_n;

  logic [15:0] total_len, udp_len, ip_csum;
  logic [7:0]  hdr_byte;
  logic        needs_pad;

  assign total_len       = 16'(IP_HDR_LEN + UDP_HDR_LEN) + 16'(len_q);
  assign udp_len         = 16'(UDP_HDR_LEN) + 16'(len_q);
  assign needs_pad       = (11'(HDR_LEN) + len_q) < 11'(MIN_FRAME_LEN);
  assign busyOut         = (state != ST_IDLE);
  assign payloadReadyOut = (state == ST_PAY);

  ipv4_csum #(
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP),
    .IP_TTL (IP_TTL)
  ) u_csum (
    .clk       (clkIn),
    .rst       (rstIn),
    .total_len (total_len),
    .ident     (frame_id),
    .csum      (ip_csum)
  );

  // Header byte for the current frame offset (all fields big-endian).
  always_comb begin
    hdr_byte = '0;
    case (cnt[5:0])
      6'd0:  hdr_byte = DST_MAC[47:40];
      6'd1:  hdr_byte = DST_MAC[39:32];
      6'd2:  hdr_byte = DST_MAC[31:24];
      6'd3:  hdr_byte = DST_MAC[23:16];
      6'd4:  hdr_byte = DST_MAC[15:8];
      6'd5:  hdr_byte = DST_MAC[7:0];
      6'd6:  hdr_byte = SRC_MAC[47:40];
      6'd7:  hdr_byte = SRC_MAC[39:32];
      6'd8:  hdr_byte = SRC_MAC[31:24];
      6'd9:  hdr_byte = SRC_MAC[23:16];
      6'd10: hdr_byte = SRC_MAC[15:8];
      6'd11: hdr_byte = SRC_MAC[7:0];
      6'd12: hdr_byte = ETHERTYPE_IPV4[15:8];
      6'd13: hdr_byte = ETHERTYPE_IPV4[7:0];
      6'd14: hdr_byte = IPV4_VER_IHL[15:8];
      6'd15: hdr_byte = IPV4_VER_IHL[7:0];
      6'd16: hdr_byte = total_len[15:8];
      6'd17: hdr_byte = total_len[7:0];
      6'd18: hdr_byte = frame_id[15:8];
      6'd19: hdr_byte = frame_id[7:0];
      6'd20: hdr_byte = IPV4_FLAGS_DF[15:8];
      6'd21: hdr_byte = IPV4_FLAGS_DF[7:0];
      6'd22: hdr_byte = IP_TTL;
      6'd23: hdr_byte = IP_PROTO_UDP;
      6'd24: hdr_byte = ip_csum[15:8];
      6'd25: hdr_byte = ip_csum[7:0];
      6'd26: hdr_byte = SRC_IP[31:24];
      6'd27: hdr_byte = SRC_IP[23:16];
      6'd28: hdr_byte = SRC_IP[15:8];
      6'd29: hdr_byte = SRC_IP[7:0];
      6'd30: hdr_byte = DST_IP[31:24];
      6'd31: hdr_byte = DST_IP[23:16];
      6'd32: hdr_byte = DST_IP[15:8];
      6'd33: hdr_byte = DST_IP[7:0];
      6'd34: hdr_byte = SRC_PORT[15:8];
      6'd35: hdr_byte = SRC_PORT[7:0];
      6'd36: hdr_byte = DST_PORT[15:8];
      6'd37: hdr_byte = DST_PORT[7:0];
      6'd38: hdr_byte = udp_len[15:8];
      6'd39: hdr_byte = udp_len[7:0];
      default: hdr_byte = '0;
    endcase
  end

  // Next-state and next-output logic; cnt is the CSUM wait counter, then the
  // frame byte offset, then the IFG counter.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    len_n       = len_q;
    frame_id_n  = frame_id;
    id_cnt_n    = id_cnt;
    tx_data_n   = '0;
    tx_valid_n  = 1'b0;
    tx_err_n    = 1'b0;
    done_n      = 1'b0;
    start_err_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startIn) begin
          if (payloadLenIn == '0 || payloadLenIn > 11'(MAX_PAYLOAD)) begin
            start_err_n = 1'b1;
          end else begin
            len_n      = payloadLenIn;
            frame_id_n = id_cnt;
            cnt_n      = '0;
            state_n    = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (cnt == 11'(CSUM_LATENCY - 1)) begin
          cnt_n    = '0;
          id_cnt_n = id_cnt + 16'd1;
          state_n  = ST_HDR;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      ST_HDR: begin
        tx_data_n  = hdr_byte;
        tx_valid_n = 1'b1;
        cnt_n      = cnt + 11'd1;
        if (cnt == 11'(HDR_LEN - 1)) state_n = ST_PAY;
      end
      ST_PAY: begin
        if (payloadValidIn) begin
          tx_data_n  = payloadDataIn;
          tx_valid_n = 1'b1;
          cnt_n      = cnt + 11'd1;
          if (cnt == 11'(HDR_LEN - 1) + len_q) begin
            if (needs_pad) begin
              state_n = ST_PAD;
            end else begin
              done_n  = 1'b1;
              cnt_n   = '0;
              state_n = ST_IFG;
            end
          end
        end else begin
          tx_err_n = 1'b1;
          cnt_n    = '0;
          state_n  = ST_IFG;
        end
      end
      ST_PAD: begin
        tx_valid_n = 1'b1;
        cnt_n      = cnt + 11'd1;
        if (cnt == 11'(MIN_FRAME_LEN - 1)) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = ST_IFG;
        end
      end
      ST_IFG: begin
        // The first IFG cycle carries the registered last byte, so the count
        // runs one past IFG_CYCLES to give IFG_CYCLES fully idle cycles.
        if (cnt == 11'(IFG_CYCLES)) state_n = ST_IDLE;
        else cnt_n = cnt + 11'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters and registered tx outputs.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      len_q          <= '0;
      frame_id       <= '0;
      id_cnt         <= '0;
      txDataOut      <= '0;
      txDataValidOut <= 1'b0;
      txErrOut       <= 1'b0;
      frameDoneOut   <= 1'b0;
      startErrOut    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      len_q          <= len_n;
      frame_id       <= frame_id_n;
      id_cnt         <= id_cnt_n;
      txDataOut      <= tx_data_n;
      txDataValidOut <= tx_valid_n;
      txErrOut       <= tx_err_n;
      frameDoneOut   <= done_n;
      startErrOut    <= start_err_n;
    end
  end

endmodule

// File: tb/tb_eth_udp_tx_builder.sv
// Self-checking bench for eth_udp_tx_builder: a frame-level model builds the
// expected byte stream, one compare process checks every valid output byte.
`timescale 1ns/1ps
module tb_eth_udp_tx_builder;

  localparam logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01;
  localparam logic [47:0] DST_MAC     = 48'h01_00_5E_36_0C_6F;
  localparam logic [31:0] SRC_IP      = 32'hC0A8_010A;
  localparam logic [31:0] DST_IP      = 32'hE936_0C6F;
  localparam logic [15:0] SRC_PORT    = 16'd26400;
  localparam logic [15:0] DST_PORT    = 16'd26477;
  localparam logic [7:0]  IP_TTL      = 8'd64;
  localparam int unsigned MAX_PAYLOAD = 1472;
  localparam int unsigned IFG_CYCLES  = 12;

  logic        clkIn = 1'b0;
  logic        rstIn, startIn, busyOut;
  logic [10:0] payloadLenIn;
  logic [7:0]  payloadDataIn;
  logic        payloadValidIn, payloadReadyOut;
  logic [7:0]  txDataOut;
  logic        txDataValidOut, txErrOut, frameDoneOut, startErrOut;

  eth_udp_tx_builder #(
    .SRC_MAC     (SRC_MAC),
    .DST_MAC     (DST_MAC),
    .SRC_IP      (SRC_IP),
    .DST_IP      (DST_IP),
    .SRC_PORT    (SRC_PORT),
    .DST_PORT    (DST_PORT),
    .IP_TTL      (IP_TTL),
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .IFG_CYCLES  (IFG_CYCLES)
  ) dut (
    .clkIn           (clkIn),
    .rstIn           (rstIn),
    .startIn         (startIn),
    .payloadLenIn    (payloadLenIn),
    .busyOut         (busyOut),
    .payloadDataIn   (payloadDataIn),
    .payloadValidIn  (payloadValidIn),
    .payloadReadyOut (payloadReadyOut),
    .txDataOut       (txDataOut),
    .txDataValidOut  (txDataValidOut),
    .txErrOut        (txErrOut),
    .frameDoneOut    (frameDoneOut),
    .startErrOut     (startErrOut)
  );

  always #4 clkIn = ~clkIn;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int serr_cnt = 0;
  int model_id = 0;

  logic [7:0] model_buf[$];
  logic [7:0] exp_q[$];
  bit         last_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] cap_a[$];
  logic [7:0] pay_mem[0:2047];

  always @(posedge clkIn) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clkIn);
    #1;
  endtask

  // One's-complement sum of the header words, folded until no carry remains.
  function automatic logic [15:0] model_csum(input int len, input int id);
    int unsigned w[10];
    int unsigned s;
    w[0] = 32'h4500;
    w[1] = 28 + len;
    w[2] = id & 32'hFFFF;
    w[3] = 32'h4000;
    w[4] = {16'd0, IP_TTL, 8'd17};
    w[5] = {16'd0, SRC_IP[31:16]};
    w[6] = {16'd0, SRC_IP[15:0]};
    w[7] = {16'd0, DST_IP[31:16]};
    w[8] = {16'd0, DST_IP[15:0]};
    w[9] = 0;
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(~s);
  endfunction

  function automatic void push_be(input logic [47:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) model_buf.push_back(v[8*i +: 8]);
  endfunction

  function automatic void build_frame(input int len, input int id);
    model_buf.delete();
    push_be(DST_MAC, 6);
    push_be(SRC_MAC, 6);
    push_be(48'h0800, 2);
    push_be(48'h4500, 2);
    push_be(48'(28 + len), 2);
    push_be(48'(id), 2);
    push_be(48'h4000, 2);
    push_be(48'(IP_TTL), 1);
    push_be(48'd17, 1);
    push_be(48'(model_csum(len, id)), 2);
    push_be(48'(SRC_IP), 4);
    push_be(48'(DST_IP), 4);
    push_be(48'(SRC_PORT), 2);
    push_be(48'(DST_PORT), 2);
    push_be(48'(8 + len), 2);
    push_be(48'h0000, 2);
    for (int i = 0; i < len; i++) model_buf.push_back(pay_mem[i]);
    while (model_buf.size() < 60) model_buf.push_back(8'h00);
  endfunction

  // Compare process: every valid output byte against the model stream.
  always @(negedge clkIn) begin
    if (txErrOut) begin
      err_cnt++;
      chk("err_with_valid", txDataValidOut, 1'b0);
    end
    if (frameDoneOut) done_cnt++;
    if (startErrOut) serr_cnt++;
    if (txDataValidOut) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", txDataValidOut, 1'b0);
      end else begin
        chk("tx_data", txDataOut, exp_q.pop_front());
        chk("frame_done", frameDoneOut, last_q.pop_front());
      end
      cap_q.push_back(txDataOut);
    end else begin
      chk("done_without_valid", frameDoneOut, 1'b0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      busyOut,         1'b0);
    chk({tag, "_ready"},     payloadReadyOut, 1'b0);
    chk({tag, "_data"},      txDataOut,       8'h00);
    chk({tag, "_valid"},     txDataValidOut,  1'b0);
    chk({tag, "_err"},       txErrOut,        1'b0);
    chk({tag, "_done"},      frameDoneOut,    1'b0);
    chk({tag, "_start_err"}, startErrOut,     1'b0);
  endtask

  task automatic load_expected(input int n, input bit good);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_buf[i]);
      last_q.push_back(good && (i == n - 1));
    end
  endtask

  // Runs one frame from start until busyOut falls; drop_after >= 0 withholds
  // payload after that many bytes; poke issues a start while busy.
  task automatic run_frame(input int len, input int drop_after, input bit poke,
                           output int idle_after);
    int idx, t0, err0, done0, first_lat;
    bit seen_done, finished;
    idx = 0; first_lat = -1; idle_after = 0; seen_done = 0; finished = 0;
    build_frame(len, model_id);
    load_expected((drop_after >= 0) ? 42 + drop_after : model_buf.size(), drop_after < 0);
    cap_q.delete();
    err0 = err_cnt;
    done0 = done_cnt;
    startIn = 1'b1;
    payloadLenIn = 11'(len);
    t0 = cyc;
    step();
    startIn = 1'b0;
    chk("busy_rise", busyOut, 1'b1);
    for (int k = 0; k < 4000 && !finished; k++) begin
      if (poke) begin
        startIn = (k == 20);
        payloadLenIn = 11'd20;
      end
      payloadDataIn = pay_mem[idx];
      payloadValidIn = (idx < len) && (drop_after < 0 || idx < drop_after);
      if (payloadValidIn && payloadReadyOut) idx++;
      if (txDataValidOut && first_lat < 0) first_lat = cyc - t0;
      if (seen_done && busyOut && !txDataValidOut) idle_after++;
      if (frameDoneOut) seen_done = 1;
      if (!busyOut) finished = 1;
      else step();
    end
    startIn = 1'b0;
    payloadValidIn = 1'b0;
    chk("frame_finished", busyOut, 1'b0);
    chk("bytes_left", exp_q.size(), 0);
    chk("err_pulses", err_cnt - err0, (drop_after >= 0) ? 1 : 0);
    chk("done_pulses", done_cnt - done0, (drop_after >= 0) ? 0 : 1);
    chk("first_byte_latency", first_lat, 5);
    model_id++;
  endtask

  task automatic bad_start(input int len);
    int s0;
    s0 = serr_cnt;
    startIn = 1'b1;
    payloadLenIn = 11'(len);
    step();
    startIn = 1'b0;
    chk("start_err_pulse", startErrOut, 1'b1);
    chk("busy_after_bad_start", busyOut, 1'b0);
    repeat (4) step();
    chk("start_err_once", serr_cnt - s0, 1);
    chk("busy_stays_low", busyOut, 1'b0);
  endtask

  task automatic reset_mid_pay();
    int idx;
    bit hit;
    idx = 0; hit = 0;
    build_frame(20, model_id);
    load_expected(62, 1'b1);
    startIn = 1'b1;
    payloadLenIn = 11'd20;
    step();
    startIn = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (payloadReadyOut && idx >= 3) begin
        hit = 1;
      end else begin
        payloadDataIn = pay_mem[idx];
        payloadValidIn = 1'b1;
        if (payloadReadyOut) idx++;
        step();
      end
    end
    chk("reset_reached_pay", hit, 1'b1);
    rstIn = 1'b1;
    payloadValidIn = 1'b0;
    exp_q.delete();
    last_q.delete();
    step();
    chk_all_zero("mid_reset");
    rstIn = 1'b0;
    model_id = 0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    rstIn = 1'b1;
    startIn = 1'b0;
    payloadLenIn = '0;
    payloadDataIn = '0;
    payloadValidIn = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rstIn = 1'b0;
    step();

    for (int i = 0; i < 20; i++) pay_mem[i] = 8'(i);

    // Pin the model against hand-computed header values.
    build_frame(20, 0);
    chk("model_len", model_buf.size(), 62);
    chk("model_csum_hi", model_buf[24], 8'h83);
    chk("model_csum_lo", model_buf[25], 8'h65);
    chk("model_udp_len", {model_buf[38], model_buf[39]}, 16'h001C);
    chk("model_csum_id1", model_csum(20, 1), 16'h8364);

    // Frame 1: len 20, id 0.
    run_frame(20, -1, 1'b0, idle);
    chk("ifg_idle_1", idle, 12);
    chk("f1_len", cap_q.size(), 62);
    chk("f1_csum", {cap_q[24], cap_q[25]}, 16'h8365);
    chk("f1_total_len", {cap_q[16], cap_q[17]}, 16'h0030);
    chk("f1_udp_len", {cap_q[38], cap_q[39]}, 16'h001C);
    chk("f1_last_pay", cap_q[61], 8'h13);
    cap_a = cap_q;

    // Frame 2 back-to-back, with an ignored start during busy.
    run_frame(20, -1, 1'b1, idle);
    chk("ifg_idle_2", idle, 12);
    chk("f2_ident", {cap_q[18], cap_q[19]}, 16'h0001);
    chk("f2_csum", {cap_q[24], cap_q[25]}, 16'h8364);

    // Short frame padded to 60 bytes.
    for (int i = 0; i < 4; i++) pay_mem[i] = 8'(8'hA0 + i);
    run_frame(4, -1, 1'b0, idle);
    chk("f3_len", cap_q.size(), 60);
    chk("f3_udp_len", {cap_q[38], cap_q[39]}, 16'h000C);
    chk("f3_total_len", {cap_q[16], cap_q[17]}, 16'h0020);
    chk("f3_pay0", cap_q[42], 8'hA0);
    for (int i = 46; i < 60; i++) chk("f3_pad_zero", cap_q[i], 8'h00);

    // Underrun after 5 payload bytes, then a good frame.
    for (int i = 0; i < 20; i++) pay_mem[i] = 8'(i * 13 + 5);
    run_frame(20, 5, 1'b0, idle);
    chk("abort_len", cap_q.size(), 47);
    run_frame(20, -1, 1'b0, idle);
    chk("ifg_idle_5", idle, 12);
    chk("f5_ident", {cap_q[18], cap_q[19]}, 16'h0004);

    // Rejected lengths.
    bad_start(0);
    bad_start(1473);

    // Reset in the middle of the payload, then frame 1 again.
    for (int i = 0; i < 20; i++) pay_mem[i] = 8'(i);
    reset_mid_pay();
    run_frame(20, -1, 1'b0, idle);
    chk("after_reset_len", cap_q.size(), 62);
    chk("after_reset_ident", {cap_q[18], cap_q[19]}, 16'h0000);
    chk("after_reset_csum", {cap_q[24], cap_q[25]}, 16'h8365);
    for (int i = 0; i < 62 && i < cap_q.size(); i++) chk("after_reset_match", cap_q[i], cap_a[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
